// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: stage occupancy encodings and the
// decode/execute payload field layout used to pack the stage bus.
package msrv32_pkg;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_MAIN  = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // Stage state doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = OCC_EMPTY,
      ST_MAIN  = OCC_MAIN,
      ST_FULL  = OCC_FULL
   } stage_state_t;

   // Decode/execute payload field widths.
   localparam int RD_ADDR_W    = 5;
   localparam int CSR_ADDR_W   = 12;
   localparam int RS1_W        = 32;
   localparam int RS2_W        = 32;
   localparam int PC_W         = 32;
   localparam int PC_PLUS_4_W  = 32;
   localparam int IADDER_W     = 32;
   localparam int ALU_OPCODE_W = 4;
   localparam int LOAD_SIZE_W  = 2;
   localparam int IMM_W        = 32;
   localparam int CTRL_W       = 8;

   // Field offsets, packed LSB first in the order listed above.
   localparam int RD_ADDR_LSB    = 0;
   localparam int CSR_ADDR_LSB   = RD_ADDR_LSB    + RD_ADDR_W;
   localparam int RS1_LSB        = CSR_ADDR_LSB   + CSR_ADDR_W;
   localparam int RS2_LSB        = RS1_LSB        + RS1_W;
   localparam int PC_LSB         = RS2_LSB        + RS2_W;
   localparam int PC_PLUS_4_LSB  = PC_LSB         + PC_W;
   localparam int IADDER_LSB     = PC_PLUS_4_LSB  + PC_PLUS_4_W;
   localparam int ALU_OPCODE_LSB = IADDER_LSB     + IADDER_W;
   localparam int LOAD_SIZE_LSB  = ALU_OPCODE_LSB + ALU_OPCODE_W;
   localparam int IMM_LSB        = LOAD_SIZE_LSB  + LOAD_SIZE_W;
   localparam int CTRL_LSB       = IMM_LSB        + IMM_W;
   localparam int DEC_EXE_W      = CTRL_LSB       + CTRL_W;

   // Occupancy count for a given stage state.
   function automatic logic [1:0] state_to_occ(input stage_state_t st);
      return logic'(st == ST_FULL) ? OCC_FULL :
             (st == ST_MAIN)       ? OCC_MAIN : OCC_EMPTY;
   endfunction

endpackage

// File: rtl/msrv32_pipe_stage_reg.sv
// Handshaked pipeline stage register with a 2-entry (main + skid) buffer
// and synchronous flush. in_ready_out is fully registered so there is no
// combinational path from out_ready_in back upstream.
module msrv32_pipe_stage_reg
   import msrv32_pkg::*;
#(
   parameter int         DATA_W         = 32,
   parameter bit         CLEAR_ON_FLUSH = 1'b0,
   parameter logic [255:0] RESET_DATA   = '0
) (
   input  logic              ms_risc32_mp_clk_in,
   input  logic              ms_risc32_mp_rst_in,
   input  logic              flush_in,
   input  logic              in_valid_in,
   input  logic [DATA_W-1:0] in_data_in,
   output logic              in_ready_out,
   output logic              out_valid_out,
   output logic [DATA_W-1:0] out_data_out,
   input  logic              out_ready_in,
   output logic [1:0]        occupancy_out
);

   localparam logic [DATA_W-1:0] RST_DATA = RESET_DATA[DATA_W-1:0];

   stage_state_t      r_state;
   stage_state_t      w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] w_main_nxt;
   logic [DATA_W-1:0] w_skid_nxt;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [1:0]        r_occ;
   logic              w_xfer_in;
   logic              w_xfer_out;

   assign w_xfer_in  = in_valid_in & r_in_ready;
   assign w_xfer_out = r_out_valid & out_ready_in;

   // Next state and payload: FIFO order, main is always the head entry.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_xfer_in) begin
               w_state_nxt = ST_MAIN;
               w_main_nxt  = in_data_in;
            end
         end
         ST_MAIN: begin
            if (w_xfer_in && w_xfer_out) begin
               w_main_nxt = in_data_in;
            end else if (w_xfer_in) begin
               w_state_nxt = ST_FULL;
               w_skid_nxt  = in_data_in;
            end else if (w_xfer_out) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_xfer_out) begin
               w_state_nxt = ST_MAIN;
               w_main_nxt  = r_skid;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush overrides every handshake; a same-cycle input is dropped.
      if (flush_in) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = CLEAR_ON_FLUSH ? '0 : r_main;
         w_skid_nxt  = CLEAR_ON_FLUSH ? '0 : r_skid;
      end
   end

   // State, payload and registered status outputs.
   always_ff @(posedge ms_risc32_mp_clk_in) begin
      if (ms_risc32_mp_rst_in) begin
         r_state     <= ST_EMPTY;
         r_main      <= RST_DATA;
         r_skid      <= RST_DATA;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= OCC_EMPTY;
      end else begin
         r_state     <= w_state_nxt;
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_in_ready  <= (w_state_nxt != ST_FULL);
         r_occ       <= state_to_occ(w_state_nxt);
      end
   end

   assign in_ready_out  = r_in_ready;
   assign out_valid_out = r_out_valid;
   assign out_data_out  = r_main;
   assign occupancy_out = r_occ;

endmodule

// File: tb/tb_msrv32_pipe_stage_reg.sv
// Bench for msrv32_pipe_stage_reg: two instances (hold-on-flush and
// clear-on-flush) share stimulus; a directed table and a random run are
// checked against constants and a queue-based reference model.
module tb_msrv32_pipe_stage_reg;

   localparam logic [31:0] RD = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst, flush, vin, ordy;
   logic [31:0] din;
   logic        rdy0, vld0, rdy1, vld1;
   logic [31:0] dat0, dat1;
   logic [1:0]  occ0, occ1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   msrv32_pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b0), .RESET_DATA(256'hDEAD_BEEF)) dut0 (
      .ms_risc32_mp_clk_in(clk), .ms_risc32_mp_rst_in(rst), .flush_in(flush),
      .in_valid_in(vin), .in_data_in(din), .in_ready_out(rdy0),
      .out_valid_out(vld0), .out_data_out(dat0), .out_ready_in(ordy),
      .occupancy_out(occ0));

   msrv32_pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1), .RESET_DATA(256'hDEAD_BEEF)) dut1 (
      .ms_risc32_mp_clk_in(clk), .ms_risc32_mp_rst_in(rst), .flush_in(flush),
      .in_valid_in(vin), .in_data_in(din), .in_ready_out(rdy1),
      .out_valid_out(vld1), .out_data_out(dat1), .out_ready_in(ordy),
      .occupancy_out(occ1));

   // Reference model: held entries as a FIFO plus the word each DUT shows.
   logic [31:0] q[$];
   logic [31:0] disp0 = RD;
   logic [31:0] disp1 = RD;

   typedef struct {
      logic rst, fl, vin; logic [31:0] din; logic ordy;
      logic vld, rdy; logic [1:0] occ; logic [31:0] d0, d1;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input logic ev, input logic er,
                        input logic [1:0] eo, input logic [31:0] e0, input logic [31:0] e1);
      vectors++;
      if (vld0 !== ev || rdy0 !== er || occ0 !== eo || dat0 !== e0) begin
         miscompares++;
         $display("FAIL %s hold-inst: got vld=%0b rdy=%0b occ=%0d data=%h, want vld=%0b rdy=%0b occ=%0d data=%h",
                  nm, vld0, rdy0, occ0, dat0, ev, er, eo, e0);
      end
      vectors++;
      if (vld1 !== ev || rdy1 !== er || occ1 !== eo || dat1 !== e1) begin
         miscompares++;
         $display("FAIL %s clear-inst: got vld=%0b rdy=%0b occ=%0d data=%h, want vld=%0b rdy=%0b occ=%0d data=%h",
                  nm, vld1, rdy1, occ1, dat1, ev, er, eo, e1);
      end
   endtask

   // Drive one cycle, advance the model across the edge, sample at +1.
   task automatic step(input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic o);
      bit tin, tout;
      rst = r; flush = f; vin = v; din = d; ordy = o;
      tin  = v && (q.size() < 2);
      tout = (q.size() > 0) && o;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete(); disp0 = RD; disp1 = RD;
      end else if (f) begin
         q.delete(); disp1 = '0;
      end else begin
         if (tout) void'(q.pop_front());
         if (tin)  q.push_back(d);
         if (q.size() > 0) begin disp0 = q[0]; disp1 = q[0]; end
      end
      check("model", q.size() > 0, q.size() < 2, 2'(q.size()), disp0, disp1);
   endtask

   task automatic add(input logic r, input logic f, input logic v, input logic [31:0] d,
                      input logic o, input logic ev, input logic er, input logic [1:0] eo,
                      input logic [31:0] e0, input logic [31:0] e1);
      tbl.push_back('{r, f, v, d, o, ev, er, eo, e0, e1});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; vin = 1'b0; din = '0; ordy = 1'b0;

      // Reset held two cycles with input offered: input ignored.
      add(1,0,1,32'h55,1, 0,1,0, RD,RD);
      add(1,0,1,32'h55,1, 0,1,0, RD,RD);
      // Single transfer, 1-cycle latency, then empty.
      add(0,0,1,32'h6,1, 1,1,1, 32'h6,32'h6);
      add(0,0,0,32'h0,1, 0,1,0, 32'h6,32'h6);
      // Streaming 1..8 at full rate.
      for (int k = 1; k <= 8; k++) add(0,0,1,32'(k),1, 1,1,1, 32'(k),32'(k));
      add(0,0,0,0,1, 0,1,0, 32'h8,32'h8);
      // Back-pressure: fill to two, offered 0xC refused, then drain in order.
      add(0,0,1,32'hA,0, 1,1,1, 32'hA,32'hA);
      add(0,0,1,32'hB,0, 1,0,2, 32'hA,32'hA);
      add(0,0,1,32'hC,0, 1,0,2, 32'hA,32'hA);
      add(0,0,0,0,1,     1,1,1, 32'hB,32'hB);
      add(0,0,0,0,1,     0,1,0, 32'hB,32'hB);
      // Flush when full while pushing 0xC.
      add(0,0,1,32'hA,0, 1,1,1, 32'hA,32'hA);
      add(0,0,1,32'hB,0, 1,0,2, 32'hA,32'hA);
      add(0,1,1,32'hC,0, 0,1,0, 32'hA,32'h0);
      add(0,0,0,0,1,     0,1,0, 32'hA,32'h0);
      // Flush while holding 0x12.
      add(0,0,1,32'h12,0, 1,1,1, 32'h12,32'h12);
      add(0,1,0,0,0,      0,1,0, 32'h12,32'h0);
      // Multi-cycle flush discards every input.
      add(0,1,1,32'h33,1, 0,1,0, 32'h12,32'h0);
      add(0,1,1,32'h34,1, 0,1,0, 32'h12,32'h0);
      // Flush coinciding with an output transfer.
      add(0,0,1,32'h40,0, 1,1,1, 32'h40,32'h40);
      add(0,1,0,0,1,      0,1,0, 32'h40,32'h0);
      // Reset together with flush.
      add(0,0,1,32'h50,0, 1,1,1, 32'h50,32'h50);
      add(1,1,1,32'h77,0, 0,1,0, RD,RD);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].fl, tbl[i].vin, tbl[i].din, tbl[i].ordy);
         check($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].rdy, tbl[i].occ, tbl[i].d0, tbl[i].d1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0,199) == 0, $urandom_range(0,29) == 0,
              $urandom_range(0,3) != 0, $urandom, $urandom_range(0,1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/msrv32_pipe_stage_reg.md
Name: msrv32_pipe_stage_reg

Overview:
Parametrised, handshaked pipeline stage register for the msrv32 core. It replaces fixed-width, always-advancing inter-stage register blocks with a generic DATA_W payload stage. The stage has valid/ready flow control, a 2-entry skid buffer for full throughput under back-pressure, and a synchronous flush for branch/trap kill. It is instantiated between decode/execute and execute/writeback, with the stage's control and datapath fields packed into one payload bus.

Parameters:
DATA_W, 32, payload width in bits (1..256).
CLEAR_ON_FLUSH, 0, 1: out_data_out and the skid payload are zeroed on flush; 0: payload is held and only valid is cleared.
RESET_DATA, 0, value loaded into the payload registers on reset (truncated to DATA_W).

Ports:
ms_risc32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
ms_risc32_mp_rst_in  input  1  synchronous active-high reset.
flush_in  input  1  kill all held and incoming transactions (branch taken / trap).
in_valid_in  input  1  upstream has a payload.
in_data_in  input  DATA_W  upstream payload.
in_ready_out  output  1  stage can accept; registered.
out_valid_out  output  1  payload valid to downstream; registered.
out_data_out  output  DATA_W  payload to downstream; registered.
out_ready_in  input  1  downstream accepts.
occupancy_out  output  2  number of held entries (0, 1 or 2).

Behaviour:
- Reset (sampled at the clock edge, dominates everything): out_valid_out=0, skid entry empty, in_ready_out=1, occupancy_out=0, out_data_out=RESET_DATA, skid data=RESET_DATA.
- Handshake: transfer_in = in_valid_in & in_ready_out; transfer_out = out_valid_out & out_ready_in.
- Once asserted, out_valid_out stays high with stable out_data_out until transfer_out or flush/reset.
- in_ready_out depends only on registers (no comb path from out_ready_in): in_ready_out = !skid_valid.
- States: EMPTY (occ 0), MAIN (occ 1, main valid), FULL (occ 2, main+skid valid).
- EMPTY: transfer_in -> MAIN, main<=in_data_in. Latency is 1 cycle from in-handshake to out_valid_out.
- MAIN: transfer_in & transfer_out -> MAIN, main<=in_data_in (throughput 1/cycle).
- MAIN: transfer_in & !transfer_out -> FULL, skid<=in_data_in, and in_ready_out drops next cycle.
- MAIN: !transfer_in & transfer_out -> EMPTY.
- FULL: transfer_out -> MAIN, main<=skid. No input is accepted because in_ready_out=0.
- FULL: !transfer_out -> hold.
- Order is strictly FIFO; no payload is dropped or duplicated except by flush.
- Flush (priority below reset, above all handshakes): next state EMPTY, occupancy 0, in_ready_out=1.
  - An input handshaked in the same cycle as flush is discarded.
  - A downstream transfer_out in the flush cycle still counts as completed (downstream already consumed it).
  - If CLEAR_ON_FLUSH=1, main and skid payload are zeroed; else they retain their values.
- Flush held high for multiple cycles keeps the stage EMPTY and accepts/discards every input.
- occupancy_out is registered and always consistent with the valid bits: 0 only if out_valid_out=0, and 2 only if in_ready_out=0.
- Payload is never sign- or zero-extended inside the block; width conversion is the instantiator's responsibility.

Decomposition:
- Shared package msrv32_pkg: occupancy encodings (OCC_EMPTY=2'd0, OCC_MAIN=2'd1, OCC_FULL=2'd2).
- The same package holds the stage payload field offset/width constants used to pack and unpack the decode/execute bus (rd_addr, csr_addr, rs1, rs2, pc, pc_plus_4, iadder, alu_opcode, load_size, imm, control bits).
- No sub-module: the skid entry is inline; the main/skid register pair is simple enough.
- Optional thin wrapper msrv32_reg_block_3 packs the named decode/execute fields onto DATA_W and instantiates this block.

Test Plan:
- Reset: hold rst 2 cycles with in_valid_in=1 -> out_valid_out=0, in_ready_out=1, occupancy_out=0, out_data_out=RESET_DATA. The input is ignored.
- Single transfer: out_ready_in=1, push 32'h0000_0006 one cycle -> out_valid_out=1 with data 32'h6 exactly 1 cycle later, then 0 the following cycle; occupancy 1 then 0.
- Streaming: out_ready_in=1, push 8 consecutive values 1..8 -> outputs 1..8 on 8 consecutive cycles, in_ready_out never drops.
- Back-pressure: out_ready_in=0, push 0xA then 0xB -> occupancy 2, in_ready_out=0, out_data_out holds 0xA. Raise out_ready_in -> 0xA then 0xB emerge on successive cycles, in_ready_out returns 1.
- Flush when FULL with CLEAR_ON_FLUSH=1 (same stimulus, then pulse flush_in while pushing 0xC) -> next cycle out_valid_out=0, occupancy 0, out_data_out=0, and 0xC never appears.
- Flush with CLEAR_ON_FLUSH=0, stage holding 0x12 -> out_valid_out=0 and out_data_out still 0x12. Reset asserted together with flush -> reset values (RESET_DATA).
